spi_mem_responder: RTL and testbench
====================================

Name: spi_mem_responder

Overview:
SPI memory responder (slave) that answers the CPU's SPI memory master, i.e. the other end of the sclk/mosi/cs/miso link. It decodes READ and WRITE commands with 24-bit addresses. It serves bytes from a small internal byte-array memory, which can stand in for the external SPI SRAM in simulation and on-chip loopback builds. A backdoor port preloads and inspects the memory.

Parameters:
MEM_BYTES, 64, backing store size in bytes; power of two, 4..256.
AW, $clog2(MEM_BYTES), internal address width; derived, not overridden.

Ports:
clk  in  1  system clock; same domain as the SPI master.
rst_n  in  1  synchronous, active-low reset.
sclk  in  1  SPI clock from master; idles low (mode 0).
mosi  in  1  master-out data, MSB first.
cs  in  1  chip select, active-low.
miso  out  1  slave-out data.
busy  out  1  high while a transaction is in progress (cs low).
cmd_err  out  1  sticky: an unsupported opcode was received; cleared by reset.
bk_we  in  1  backdoor write strobe.
bk_addr  in  AW  backdoor address.
bk_wdata  in  8  backdoor write data.
bk_rdata  out  8  combinational mem[bk_addr].

Behaviour:
- Reset (rst_n low at posedge clk):
  - state=IDLE, miso=0, busy=0, cmd_err=0.
  - Bit counter, shift registers and sclk_q cleared.
  - Memory contents are not cleared.
- Edge detection:
  - sclk_q registers sclk every clk.
  - rise = sclk & ~sclk_q; fall = ~sclk & sclk_q.
  - Master guarantees sclk high and low each >= 2 clk cycles.
- SPI mode 0:
  - Sample mosi on rise.
  - Change miso on fall.
  - MSB first.
- cs high at any clk edge:
  - state<=IDLE, bit counter<=0, miso<=0, busy<=0.
  - Any partially received byte is discarded.
  - Abort mid-operation is legal.
- States:
  - IDLE:
    - cs low -> CMD, busy<=1.
  - CMD:
    - Shift 8 mosi bits.
    - On 8th rise: 0x03 -> ADDR (read); 0x02 -> ADDR (write); other -> IGNORE, cmd_err<=1.
  - ADDR:
    - Shift 24 bits.
    - On 24th rise, latch addr<=bits[AW-1:0]; upper bits ignored, so addresses alias.
    - Go to RDATA or WDATA.
  - RDATA:
    - Cycle after entry: tx<=mem[addr].
    - Each fall: miso<=tx[7], tx<=tx<<1, bitcnt++.
    - After 8th fall of a byte: addr<=addr+1 mod MEM_BYTES and tx<=mem[new addr], ready for the next fall.
    - First data bit is therefore valid after the first fall following the last address rise, before the next rise.
  - WDATA:
    - Shift 8 bits on rise.
    - On 8th rise: mem[addr]<=byte, addr<=addr+1 mod MEM_BYTES.
    - Incomplete final byte is never written.
  - IGNORE:
    - miso held 0 until cs high.
- miso is 0 in every state except RDATA.
- Wrap-around: address MEM_BYTES-1 increments to 0 in both read and write.
- Simultaneous backdoor and SPI write in the same clk:
  - SPI write takes effect; backdoor write is dropped.
  - Otherwise bk_we writes at posedge clk.
- Read-after-write within one transaction reads the updated memory.
- Streaming length is unbounded; transfer ends only on cs high.

Decomposition:
- Shared package: SPI_CMD_READ=8'h03, SPI_CMD_WRITE=8'h02, SPI_ADDR_BITS=24, and the state enum (IDLE, CMD, ADDR, RDATA, WDATA, IGNORE).
- The SPI master uses the same opcode constants.
- One natural sub-module: spi_edge_detect (sclk_q register, rise/fall outputs).
- Memory array stays inline.

Test Plan:
1. Backdoor preload mem[0..3]=13,05,30,00. Send cs low, 0x03, 0x000000, 32 clocks -> miso bytes 0x13,0x05,0x30,0x00; busy=1 throughout; cmd_err=0.
2. Send 0x02, addr 0x000010, data 0xA5,0x5A; cs high -> bk_rdata@0x10=0xA5, @0x11=0x5A. Then READ 0x10 returns 0xA5,0x5A.
3. WRITE at addr MEM_BYTES-1 (0x3F) with data 0x11,0x22 -> mem[0x3F]=0x11, mem[0x00]=0x22. Address 0x000040 aliases to 0x00.
4. Send opcode 0x9F plus 32 clocks -> cmd_err=1, miso=0 throughout, memory unchanged. Next READ still works and cmd_err stays 1.
5. WRITE 0x20 with 0xFF, cs high after only 5 data bits -> mem[0x20] unchanged. Next transaction decodes from CMD correctly.
6. rst_n low for 1 clk mid-READ data -> miso=0, busy=0, state IDLE (cs held low re-enters CMD). Memory preserved and readable afterwards.

Source files
------------

// File: rtl/spi_mem_responder_pkg.sv
// Shared definitions for the SPI memory link: opcodes, address framing and
// the responder's protocol state encoding.
package spi_mem_responder_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
  localparam int         SPI_ADDR_BITS = 24;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    RDATA  = 3'd3,
    WDATA  = 3'd4,
    IGNORE = 3'd5
  } spi_state_t;

endpackage

// File: rtl/spi_mem_responder_edge_detect.sv
// Registers sclk once in the clk domain and flags its rising/falling edges.
// sclk is generated in the same clock domain, so no synchroniser is needed.
module spi_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  output logic rise,
  output logic fall
);

  logic sclk_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sclk_q <= 1'b0;
    else        sclk_q <= sclk;
  end

  assign rise = sclk & ~sclk_q;
  assign fall = ~sclk & sclk_q;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 memory slave: READ (0x03) / WRITE (0x02) with 24-bit addresses
// onto a small inline byte memory, plus a backdoor preload/inspect port.
module spi_mem_responder
  import spi_mem_responder_pkg::*;
#(
  parameter  int MEM_BYTES = 64,
  localparam int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sclk,
  input  logic          mosi,
  input  logic          cs,
  output logic          miso,
  output logic          busy,
  output logic          cmd_err,
  input  logic          bk_we,
  input  logic [AW-1:0] bk_addr,
  input  logic [7:0]    bk_wdata,
  output logic [7:0]    bk_rdata,
  output spi_state_t    dbg_state
);

  logic rise, fall;

  spi_edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sclk  (sclk),
    .rise  (rise),
    .fall  (fall)
  );

  logic [7:0] mem [MEM_BYTES];

  spi_state_t    state_q, state_d;
  logic [4:0]    bitcnt_q, bitcnt_d;
  logic [6:0]    shreg_q, shreg_d;
  logic          op_write_q, op_write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    tx_q, tx_d;
  logic          load_q, load_d;
  logic          miso_q, miso_d;
  logic          busy_q, busy_d;
  logic          cmd_err_q, cmd_err_d;
  logic          mem_we;
  logic [7:0]    mem_wdata;

  // Only the last 8 shifted bits matter: the opcode, or the low AW address bits.
  logic [7:0]    sh_next;
  logic [AW-1:0] addr_inc;

  assign sh_next  = {shreg_q, mosi};
  assign addr_inc = addr_q + AW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      tx_q       <= '0;
      load_q     <= 1'b0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      load_q     <= load_d;
      miso_q     <= miso_d;
      busy_q     <= busy_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    load_d     = 1'b0;
    miso_d     = miso_q;
    busy_d     = busy_q;
    cmd_err_d  = cmd_err_q;
    mem_we     = 1'b0;
    mem_wdata  = sh_next;

    if (cs) begin
      state_d  = IDLE;
      bitcnt_d = '0;
      shreg_d  = '0;
      miso_d   = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = CMD;
          busy_d   = 1'b1;
          bitcnt_d = '0;
          miso_d   = 1'b0;
        end
        CMD: begin
          if (rise) begin
            shreg_d  = sh_next[6:0];
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd7) begin
              bitcnt_d = '0;
              if (sh_next == SPI_CMD_READ) begin
                state_d    = ADDR;
                op_write_d = 1'b0;
              end else if (sh_next == SPI_CMD_WRITE) begin
                state_d    = ADDR;
                op_write_d = 1'b1;
              end else begin
                state_d   = IGNORE;
                cmd_err_d = 1'b1;
              end
            end
          end
        end
        ADDR: begin
          if (rise) begin
            shreg_d  = sh_next[6:0];
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'(SPI_ADDR_BITS - 1)) begin
              bitcnt_d = '0;
              addr_d   = sh_next[AW-1:0];
              if (op_write_q) begin
                state_d = WDATA;
              end else begin
                state_d = RDATA;
                load_d  = 1'b1;
              end
            end
          end
        end
        RDATA: begin
          // sclk stays high >= 2 clk after the last address rise, so this
          // load always lands before the first fall.
          if (load_q) tx_d = mem[addr_q];
          if (fall) begin
            miso_d   = tx_q[7];
            tx_d     = {tx_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd7) begin
              bitcnt_d = '0;
              addr_d   = addr_inc;
              tx_d     = mem[addr_inc];
            end
          end
        end
        WDATA: begin
          if (rise) begin
            shreg_d  = sh_next[6:0];
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd7) begin
              bitcnt_d = '0;
              mem_we   = 1'b1;
              addr_d   = addr_inc;
            end
          end
        end
        IGNORE: begin
          miso_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // bk_we is a single-cycle strobe with no back-pressure; an SPI write in
  // the same cycle wins and the backdoor write is lost.
  always_ff @(posedge clk) begin
    if (mem_we)     mem[addr_q]  <= mem_wdata;
    else if (bk_we) mem[bk_addr] <= bk_wdata;
  end

  assign bk_rdata  = mem[bk_addr];
  assign miso      = miso_q;
  assign busy      = busy_q;
  assign cmd_err   = cmd_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Randomised bench for spi_mem_responder: a driver issues SPI transactions,
// a monitor collects miso bytes and checks them against a memory model.
module tb_spi_mem_responder;
  import spi_mem_responder_pkg::*;

  localparam int MEM_BYTES = 64;
  localparam int AW        = $clog2(MEM_BYTES);
  localparam int HALF      = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk = 1'b0;
  logic          mosi = 1'b0;
  logic          cs = 1'b1;
  logic          miso, busy, cmd_err;
  logic          bk_we = 1'b0;
  logic [AW-1:0] bk_addr = '0;
  logic [7:0]    bk_wdata = '0;
  logic [7:0]    bk_rdata;
  spi_state_t    dbg_state;

  spi_mem_responder #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs        (cs),
    .miso      (miso),
    .busy      (busy),
    .cmd_err   (cmd_err),
    .bk_we     (bk_we),
    .bk_addr   (bk_addr),
    .bk_wdata  (bk_wdata),
    .bk_rdata  (bk_rdata),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mem_model [MEM_BYTES];
  logic       err_model = 1'b0;
  logic       rd_phase = 1'b0;
  logic [7:0] wr_data [8];
  logic       collide_en = 1'b0;
  logic [AW-1:0] collide_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: samples miso on every sclk rise, as the master would
  initial begin : monitor
    logic       prev_sclk;
    logic [7:0] sh;
    int         nb;
    prev_sclk = 1'b0;
    sh = '0;
    nb = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rd_phase) nb = 0;
      if (sclk && !prev_sclk && !cs) begin
        chk("busy_during_xfer", 32'(busy), 32'd1);
        if (rd_phase) begin
          sh = {sh[6:0], miso};
          nb++;
          if (nb == 8) begin
            nb = 0;
            if (exp_q.size() == 0) begin
              chk("unexpected_read_byte", 32'(sh), 32'hFFFF_FFFF);
            end else begin
              chk("read_byte", 32'(sh), 32'(exp_q.pop_front()));
            end
          end
        end else begin
          chk("miso_idle_zero", 32'(miso), 32'd0);
        end
      end
      prev_sclk = sclk;
    end
  end

  // driver tasks
  task automatic spi_bit(input logic b, input logic collide = 1'b0);
    mosi = b;
    repeat (HALF) @(negedge clk);
    sclk = 1'b1;
    if (collide) begin
      bk_we    = 1'b1;
      bk_addr  = collide_addr;
      bk_wdata = ~mem_model[collide_addr];
    end
    @(negedge clk);
    bk_we = 1'b0;
    repeat (HALF - 1) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 23; i >= 0; i--) spi_bit(a[i]);
  endtask

  task automatic cs_begin();
    @(negedge clk);
    cs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_after_cs_high", 32'(busy), 32'd0);
    chk("cmd_err", 32'(cmd_err), 32'(err_model));
  endtask

  task automatic bk_write(input int a, input logic [7:0] d);
    @(negedge clk);
    bk_we    = 1'b1;
    bk_addr  = AW'(a);
    bk_wdata = d;
    @(negedge clk);
    bk_we = 1'b0;
    mem_model[a] = d;
  endtask

  task automatic bk_check(input int a, input string name);
    @(negedge clk);
    bk_addr = AW'(a);
    #1;
    chk(name, 32'(bk_rdata), 32'(mem_model[a]));
  endtask

  task automatic spi_read(input logic [23:0] a, input int n);
    cs_begin();
    send_byte(SPI_CMD_READ);
    send_addr(a);
    rd_phase = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mem_model[(int'(a) + i) % MEM_BYTES]);
      send_byte(8'($urandom));
    end
    rd_phase = 1'b0;
    cs_end();
  endtask

  // writes wr_data[0..n-1], then optionally tail_bits bits of wr_data[n]
  task automatic spi_write(input logic [23:0] a, input int n, input int tail_bits);
    cs_begin();
    send_byte(SPI_CMD_WRITE);
    send_addr(a);
    for (int j = 0; j < n; j++)
      for (int i = 7; i >= 0; i--) spi_bit(wr_data[j][i], collide_en && j == 0 && i == 0);
    for (int i = 7; i > 7 - tail_bits; i--) spi_bit(wr_data[n][i]);
    for (int j = 0; j < n; j++) mem_model[(int'(a) + j) % MEM_BYTES] = wr_data[j];
    cs_end();
  endtask

  task automatic spi_bad(input logic [7:0] op, input int nbits);
    cs_begin();
    send_byte(op);
    for (int i = 0; i < nbits; i++) spi_bit(1'($urandom));
    err_model = 1'b1;
    cs_end();
  endtask

  initial begin : driver
    logic [7:0]  op;
    logic [23:0] a;
    int          kind, n;

    repeat (4) @(negedge clk);
    #1;
    chk("reset_miso", 32'(miso), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cmd_err", 32'(cmd_err), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;

    for (int i = 0; i < MEM_BYTES; i++) bk_write(i, 8'($urandom));

    // preload and stream four bytes from 0
    bk_write(0, 8'h13); bk_write(1, 8'h05); bk_write(2, 8'h30); bk_write(3, 8'h00);
    spi_read(24'h000000, 4);

    // write then read back
    wr_data[0] = 8'hA5; wr_data[1] = 8'h5A;
    spi_write(24'h000010, 2, 0);
    bk_check(16, "bk_after_write_10");
    bk_check(17, "bk_after_write_11");
    spi_read(24'h000010, 2);

    // wrap-around and upper-bit aliasing
    wr_data[0] = 8'h11; wr_data[1] = 8'h22;
    spi_write(24'h00003F, 2, 0);
    bk_check(63, "bk_wrap_3f");
    bk_check(0, "bk_wrap_00");
    spi_read(24'h000040, 1);
    spi_read(24'hABCD7F, 2);

    // unsupported opcode is sticky and harmless
    spi_bad(8'h9F, 32);
    spi_read(24'h000010, 2);

    // incomplete write byte is dropped
    wr_data[0] = 8'hFF;
    spi_write(24'h000020, 0, 5);
    bk_check(32, "bk_partial_write");
    spi_read(24'h000020, 1);

    // backdoor write colliding with an SPI write is lost
    collide_en = 1'b1; collide_addr = AW'(9);
    wr_data[0] = 8'h3C;
    spi_write(24'h000008, 1, 0);
    collide_en = 1'b0;
    bk_check(8, "bk_collide_spi");
    bk_check(9, "bk_collide_dropped");

    // reset mid-read
    cs_begin();
    send_byte(SPI_CMD_READ);
    send_addr(24'h000010);
    rd_phase = 1'b1;
    exp_q.push_back(mem_model[16]);
    send_byte(8'h00);
    for (int i = 0; i < 4; i++) spi_bit(1'b0);
    rd_phase = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_miso", 32'(miso), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    err_model = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_reenter_state", 32'(dbg_state), 32'(CMD));
    chk("rst_reenter_busy", 32'(busy), 32'd1);
    cs_end();
    spi_read(24'h000010, 2);

    // random traffic
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 9);
      a    = 24'($urandom);
      n    = $urandom_range(1, 4);
      for (int j = 0; j < 8; j++) wr_data[j] = 8'($urandom);
      if (kind <= 3)      spi_read(a, n);
      else if (kind <= 7) spi_write(a, n, 0);
      else if (kind == 8) begin
        op = 8'($urandom);
        if (op == SPI_CMD_READ || op == SPI_CMD_WRITE) op = 8'hC7;
        spi_bad(op, $urandom_range(0, 20));
      end else            spi_write(a, n, $urandom_range(1, 7));
    end

    for (int i = 0; i < MEM_BYTES; i++) bk_check(i, "final_mem");
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
